// File: rtl/param_tick_gen.sv
// param_tick_gen: programmable enable-strobe generator.
// In RUN it raises a single-cycle tick every D clocks, where D is a divisor
// loaded while IDLE. Optional burst support (compile-time macro
// PARAM_TICK_GEN_BURST_EN) ends the run after burst_len ticks and pulses done.
// Without the macro burst_len has no effect, done is tied low, and a run
// ends only on stop or reset.
module param_tick_gen #(
    parameter int MAX_DIV     = 32768,
    parameter int DEFAULT_DIV = 1000,
    parameter int BURST_W     = 16,
    localparam int W          = $clog2(MAX_DIV + 1)
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               start,
    input  logic               stop,
    input  logic [W-1:0]       div_in,
    input  logic               div_valid,
    output logic               div_ready,
    input  logic [BURST_W-1:0] burst_len,
    output logic               tick,
    output logic               busy,
    output logic               done,
    output logic               div_err,
    output logic [W-1:0]       phase
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [W-1:0] C_ZERO        = W'(0);
    localparam logic [W-1:0] C_ONE         = W'(1);
    localparam logic [W-1:0] C_MAX_DIV     = W'(MAX_DIV);
    localparam logic [W-1:0] C_DEFAULT_DIV = W'(DEFAULT_DIV);

    state_t       r_state;
    logic [W-1:0] r_div;
    logic [W-1:0] r_phase;
    logic         r_tick;
    logic         r_busy;
    logic         r_done;
    logic         r_div_err;
    logic         r_div_ready;

    logic [W-1:0] w_div_clamped;
    logic         w_div_over;
    logic         w_load;
    logic         w_start_ok;
    logic [W-1:0] w_start_div;
    logic         w_start_tick;
    logic [W-1:0] w_div_m1;
    logic         w_phase_wrap;
    logic [W-1:0] w_phase_next;
    logic         w_tick_next;
    logic         w_burst_end;

    // Clamp the requested divisor into 1..MAX_DIV; only the upper clamp is an error.
    always_comb begin
        w_div_clamped = div_in;
        w_div_over    = 1'b0;
        if (div_in == C_ZERO) begin
            w_div_clamped = C_ONE;
            w_div_over    = 1'b0;
        end else if (div_in > C_MAX_DIV) begin
            w_div_clamped = C_MAX_DIV;
            w_div_over    = 1'b1;
        end else begin
            w_div_clamped = div_in;
            w_div_over    = 1'b0;
        end
    end

    // A load is only possible while div_ready is high, i.e. in IDLE.
    assign w_load     = div_valid && r_div_ready;
    assign w_start_ok = start && !stop;

    // A divisor loaded on the start edge itself already governs that run.
    assign w_start_div  = w_load ? w_div_clamped : r_div;
    assign w_start_tick = (w_start_div == C_ONE);

    // The tick is aligned with the cycle whose phase is D-1, so it is
    // computed from the phase value being loaded on the same edge.
    assign w_div_m1     = r_div - C_ONE;
    assign w_phase_wrap = (r_phase == w_div_m1);
    assign w_phase_next = w_phase_wrap ? C_ZERO : (r_phase + C_ONE);
    assign w_tick_next  = (w_phase_next == w_div_m1);

`ifdef PARAM_TICK_GEN_BURST_EN
    logic [BURST_W-1:0] r_burst_len;
    logic [BURST_W-1:0] r_burst_cnt;

    // The run ends on the edge that samples the Nth tick; N=0 runs forever.
    assign w_burst_end = (r_burst_len != {BURST_W{1'b0}}) && r_tick &&
                         ((r_burst_cnt + BURST_W'(1)) == r_burst_len);

    // Latch burst_len on the start edge and count ticks while running.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_burst_len <= {BURST_W{1'b0}};
            r_burst_cnt <= {BURST_W{1'b0}};
        end else if (r_state == ST_IDLE) begin
            if (w_start_ok) begin
                r_burst_len <= burst_len;
                r_burst_cnt <= {BURST_W{1'b0}};
            end else begin
                r_burst_len <= r_burst_len;
                r_burst_cnt <= r_burst_cnt;
            end
        end else if (r_tick && (r_burst_len != {BURST_W{1'b0}})) begin
            r_burst_len <= r_burst_len;
            r_burst_cnt <= r_burst_cnt + BURST_W'(1);
        end else begin
            r_burst_len <= r_burst_len;
            r_burst_cnt <= r_burst_cnt;
        end
    end
`else
    logic w_burst_ignored;

    // burst_len remains on the port list but cannot end a run in this build;
    // ANDing with zero keeps the port referenced without giving it any effect.
    assign w_burst_ignored = |burst_len;
    assign w_burst_end     = w_burst_ignored & 1'b0;
`endif

    // Main IDLE/RUN controller; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_state     <= ST_IDLE;
            r_div       <= C_DEFAULT_DIV;
            r_phase     <= C_ZERO;
            r_tick      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_div_err   <= 1'b0;
            r_div_ready <= 1'b1;
        end else begin
            // done and div_err are single-cycle pulses unless set below.
            r_done    <= 1'b0;
            r_div_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_div     <= w_div_clamped;
                        r_div_err <= w_div_over;
                    end else begin
                        r_div     <= r_div;
                    end
                    if (w_start_ok) begin
                        r_state     <= ST_RUN;
                        r_phase     <= C_ZERO;
                        r_tick      <= w_start_tick;
                        r_busy      <= 1'b1;
                        r_div_ready <= 1'b0;
                    end else begin
                        r_state     <= ST_IDLE;
                        r_phase     <= C_ZERO;
                        r_tick      <= 1'b0;
                        r_busy      <= 1'b0;
                        r_div_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        // Stop wins over burst completion and suppresses done.
                        r_state     <= ST_IDLE;
                        r_phase     <= C_ZERO;
                        r_tick      <= 1'b0;
                        r_busy      <= 1'b0;
                        r_div_ready <= 1'b1;
                    end else if (w_burst_end) begin
                        r_state     <= ST_IDLE;
                        r_phase     <= C_ZERO;
                        r_tick      <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_div_ready <= 1'b1;
                    end else begin
                        // start is ignored here: the period is never restarted.
                        r_state     <= ST_RUN;
                        r_phase     <= w_phase_next;
                        r_tick      <= w_tick_next;
                        r_busy      <= 1'b1;
                        r_div_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_phase     <= C_ZERO;
                    r_tick      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_div_ready <= 1'b1;
                end
            endcase
        end
    end

    assign tick      = r_tick;
    assign busy      = r_busy;
    assign done      = r_done;
    assign div_err   = r_div_err;
    assign div_ready = r_div_ready;
    assign phase     = r_phase;

endmodule
